mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
Multi-cycle control FSM that sequences the shared 32-bit datapath: PC, IR, register file, the single ALU and one unified instruction/data memory port. Each cycle it drives ALU source muxes, ALU operation, write enables and the memory request from the current state, opcode, funct and alu_zero. Supported subset: add/sub/and/or/slt (R-type), addi, lw, sw, beq, j. Any other encoding traps.

Parameters:
ALU_OP_WIDTH, 3, width of alu_op; codes ADD=000 SUB=001 AND=010 OR=011 SLT=100

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write (1) / read (0)
iord  out  1  address select: 0 = PC, 1 = ALUOut register
ir_write  out  1  load IR from memory read data
pc_write  out  1  load PC
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
alu_op  out  ALU_OP_WIDTH  ALU operation
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
retired  out  1  one-cycle pulse on an instruction's final cycle
trap  out  1  illegal instruction; high until reset

Behaviour:
- Outputs are a combinational decode of the state register. The only Mealy terms are mem_ready (ir_write, pc_write in FETCH; retired in MEM_WR) and alu_zero (pc_write in BRANCH). Outputs not listed for a state are 0.
- Reset: async assertion forces RESET and drives all outputs 0 immediately, including mid-access. Memory must drop any access when mem_req falls. RESET lasts one clk after deassertion, then goes to FETCH.
- FETCH: mem_req=1, iord=0, a=0, b=01, ADD, pc_src=00. If mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay with both enables 0.
- DECODE: a=0, b=11, ADD (branch target into ALUOut). Next state:
  - R-type with legal funct (0x20/22/24/25/2A) -> R_EXEC
  - lw 0x23 / sw 0x2B -> MEM_ADDR
  - addi 0x08 -> I_EXEC
  - beq 0x04 -> BRANCH
  - j 0x02 -> JUMP
  - anything else -> TRAP
- MEM_ADDR: a=1, b=10, ADD. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retired=1, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: retired=1, go to FETCH.
- R_EXEC: a=1, b=00, alu_op from funct (20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT), then R_WB.
- R_WB: reg_write=1, reg_dst=1, retired=1, then FETCH.
- I_EXEC: a=1, b=10, ADD, then I_WB.
- I_WB: reg_write=1, reg_dst=0, retired=1, then FETCH.
- BRANCH: a=1, b=00, SUB, pc_src=01, pc_write=alu_zero, retired=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, retired=1, then FETCH.
- TRAP: trap=1, all other outputs 0. Absorbing until rst_n.
- mem_ready is ignored whenever mem_req=0. No request is ever withdrawn before mem_ready, except by reset.
- Latency in clocks with mem_ready tied high: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each cycle of memory wait adds one clock.

Decomposition:
- Package mips_pkg holds:
  - state enum (4 bits, 14 states)
  - ALU op codes
  - opcode and funct constants
  - pc_src and alu_src_b encodings
- One natural sub-module: alu_decoder (funct -> alu_op plus funct_legal flag), used in DECODE and R_EXEC.

Test Plan:
- Reset deasserted, mem_ready=1, opcode 0x00, funct 0x20 -> states RESET, FETCH, DECODE, R_EXEC, R_WB. ir_write/pc_write high in FETCH; alu_op=000 in R_EXEC; reg_write, reg_dst=1, retired in R_WB; next FETCH at cycle 5.
- lw (0x23) with mem_ready low for 2 cycles in both FETCH and MEM_RD -> mem_req held high, iord=0 then 1, no ir_write until ready, mem_to_reg=1 reg_write in MEM_WB, retired after 9 clocks.
- beq (0x04) twice, alu_zero=1 then 0 -> alu_op=001 and pc_src=01 both times; pc_write=1 first, 0 second; retired both; 3 clocks each.
- opcode 0x3F, then opcode 0x00 funct 0x03 after reset -> TRAP entered from DECODE; trap=1, mem_req=0 held 20 cycles regardless of inputs; cleared only by rst_n.
- rst_n asserted mid-MEM_WR with mem_ready low -> mem_req/mem_we drop in the same cycle without a clock edge; after release, one RESET cycle then FETCH with mem_req=1, iord=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the FSM state type, ALU operation codes, opcode/funct constants and
// the pc_src / alu_src_b mux encodings used by mc_control and alu_decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRExec,
    StRWb,
    StIExec,
    StIWb,
    StBranch,
    StJump,
    StTrap
  } state_e;

  // ALU operation codes
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  // PC source mux
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU B operand mux
  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder.
// Ports:
//   funct       in  6  IR[5:0]
//   alu_op      out 3  ALU operation for the funct (ADD when illegal)
//   funct_legal out 1  funct is one of add/sub/and/or/slt
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_legal
);

  always_comb begin
    alu_op      = AluAdd;
    funct_legal = 1'b1;
    case (funct)
      FnAdd:   alu_op = AluAdd;
      FnSub:   alu_op = AluSub;
      FnAnd:   alu_op = AluAnd;
      FnOr:    alu_op = AluOr;
      FnSlt:   alu_op = AluSlt;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the shared 32-bit MIPS datapath.
// Outputs are decoded from the state register; the only input-dependent terms
// are mem_ready (FETCH enables, MEM_WR retire) and alu_zero (BRANCH pc_write).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   opcode, funct          IR fields, valid from DECODE onward
//   alu_zero, mem_ready    datapath / memory status
//   mem_req, mem_we, iord  unified memory port control
//   ir_write, pc_write     IR / PC load enables
//   pc_src, alu_src_a/b    datapath mux selects
//   alu_op                 ALU operation
//   reg_write, reg_dst, mem_to_reg  register file write control
//   retired                pulse on an instruction's final cycle
//   trap                   illegal instruction, held until reset
module mc_control
  import mips_pkg::*;
#(
  parameter int unsigned ALU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    alu_zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    retired,
  output logic                    trap
);

  state_e     state_q, state_d;
  logic [2:0] r_alu_op;
  logic       funct_legal;
  logic [2:0] op;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_op      (r_alu_op),
    .funct_legal (funct_legal)
  );

  // Async reset drops every output (including mem_req) without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StReset;
    else        state_q <= state_d;
  end

  assign alu_op = ALU_OP_WIDTH'(op);

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PcSrcAlu;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBRegB;
    op         = AluAdd;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retired    = 1'b0;
    trap       = 1'b0;

    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = SrcBImmSh;
        case (opcode)
          OpRType:    state_d = funct_legal ? StRExec : StTrap;
          OpLw, OpSw: state_d = StMemAddr;
          OpAddi:     state_d = StIExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retired = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        op        = r_alu_op;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        op        = AluSub;
        pc_src    = PcSrcAluOut;
        pc_write  = alu_zero;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = PcSrcJump;
        pc_write = 1'b1;
        retired  = 1'b1;
        state_d  = StFetch;
      end
      StTrap:  trap = 1'b1;
      default: state_d = StTrap;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control: each step pushes the expected
// output vector, then pops it and compares against the sampled outputs.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, retired, trap;

  int checks   = 0;
  int failures = 0;
  logic [17:0] sb_q[$];

  always #5 clk = ~clk;

  mc_control #(.ALU_OP_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .retired    (retired),
    .trap       (trap)
  );

  // Vector: req we iord irw pcw pcsrc[2] a b[2] op[3] rw rd m2r ret trap
  function automatic logic [17:0] mk(logic req, logic we, logic io, logic irw, logic pcw,
                                     logic [1:0] ps, logic a, logic [1:0] b, logic [2:0] op,
                                     logic rw, logic rd, logic m2r, logic ret, logic tr);
    return {req, we, io, irw, pcw, ps, a, b, op, rw, rd, m2r, ret, tr};
  endfunction

  function automatic logic [17:0] v_zero();
    return '0;
  endfunction
  function automatic logic [17:0] v_fetch(logic r);
    return mk(1, 0, 0, r, r, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_decode();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_maddr();
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_mrd();
    return mk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_mwb();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 1, 0);
  endfunction
  function automatic logic [17:0] v_mwr(logic r);
    return mk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, r, 0);
  endfunction
  function automatic logic [17:0] v_rexec(logic [2:0] op);
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, op, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_rwb();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0, 1, 0);
  endfunction
  function automatic logic [17:0] v_iexec();
    return mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_iwb();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0, 1, 0);
  endfunction
  function automatic logic [17:0] v_branch(logic z);
    return mk(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 3'b001, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [17:0] v_jump();
    return mk(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [17:0] v_trap();
    return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1);
  endfunction

  // Pop the oldest expectation and compare against settled outputs.
  task automatic chk(input string tag);
    logic [17:0] obs, exp;
    #1;
    obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
           reg_write, reg_dst, mem_to_reg, retired, trap};
    exp = sb_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs after the falling edge, then check.
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    alu_zero  = z;
    sb_q.push_back(exp);
    chk(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(v_zero());
    chk("reset_cycle");
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    sb_q.push_back(v_zero());
    chk(tag);
  endtask

  logic [5:0] fn_tab [4];
  logic [2:0] op_tab [4];

  initial begin
    fn_tab = '{6'h22, 6'h24, 6'h25, 6'h2A};
    op_tab = '{3'b001, 3'b010, 3'b011, 3'b100};
    rst_n     = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h20;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    #2;
    assert_reset("reset_state");

    // R-type add: RESET, FETCH, DECODE, R_EXEC, R_WB
    release_reset();
    cyc("add_fetch", 1, 0, v_fetch(1));
    cyc("add_decode", 1, 1, v_decode());
    cyc("add_rexec", 1, 0, v_rexec(3'b000));
    cyc("add_rwb", 1, 0, v_rwb());

    // lw with two wait cycles in FETCH and in MEM_RD
    opcode = 6'h23;
    cyc("lw_fetch_wait0", 0, 0, v_fetch(0));
    cyc("lw_fetch_wait1", 0, 0, v_fetch(0));
    cyc("lw_fetch", 1, 0, v_fetch(1));
    cyc("lw_decode", 1, 0, v_decode());
    cyc("lw_maddr", 1, 0, v_maddr());
    cyc("lw_mrd_wait0", 0, 0, v_mrd());
    cyc("lw_mrd_wait1", 0, 0, v_mrd());
    cyc("lw_mrd", 1, 0, v_mrd());
    cyc("lw_mwb", 1, 0, v_mwb());

    // sw, no wait
    opcode = 6'h2B;
    cyc("sw_fetch", 1, 0, v_fetch(1));
    cyc("sw_decode", 1, 0, v_decode());
    cyc("sw_maddr", 1, 0, v_maddr());
    cyc("sw_mwr", 1, 0, v_mwr(1));

    // addi
    opcode = 6'h08;
    cyc("addi_fetch", 1, 0, v_fetch(1));
    cyc("addi_decode", 1, 0, v_decode());
    cyc("addi_iexec", 1, 0, v_iexec());
    cyc("addi_iwb", 1, 0, v_iwb());

    // Remaining R-type functs
    opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      funct = fn_tab[i];
      cyc("r_fetch", 1, 0, v_fetch(1));
      cyc("r_decode", 1, 0, v_decode());
      cyc("r_rexec", 1, 0, v_rexec(op_tab[i]));
      cyc("r_rwb", 1, 0, v_rwb());
    end

    // beq taken then not taken
    opcode = 6'h04;
    cyc("beq1_fetch", 1, 1, v_fetch(1));
    cyc("beq1_decode", 1, 1, v_decode());
    cyc("beq1_branch", 1, 1, v_branch(1));
    cyc("beq0_fetch", 1, 0, v_fetch(1));
    cyc("beq0_decode", 1, 1, v_decode());
    cyc("beq0_branch", 1, 0, v_branch(0));

    // j
    opcode = 6'h02;
    cyc("j_fetch", 1, 0, v_fetch(1));
    cyc("j_decode", 1, 0, v_decode());
    cyc("j_jump", 1, 0, v_jump());

    // Reset asserted mid-MEM_WR while the store is still pending
    opcode = 6'h2B;
    cyc("sw2_fetch", 1, 0, v_fetch(1));
    cyc("sw2_decode", 1, 0, v_decode());
    cyc("sw2_maddr", 1, 0, v_maddr());
    cyc("sw2_mwr_wait", 0, 0, v_mwr(0));
    assert_reset("sw2_async_reset");
    cyc("held_in_reset", 1, 0, v_zero());
    release_reset();
    cyc("post_reset_fetch", 0, 0, v_fetch(0));

    // Illegal opcode traps and holds regardless of inputs
    opcode = 6'h3F;
    cyc("ill_fetch", 1, 0, v_fetch(1));
    cyc("ill_decode", 1, 0, v_decode());
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      cyc("trap_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v_trap());
    end
    assert_reset("trap_cleared");

    // Illegal funct traps from DECODE
    opcode = 6'h00;
    funct  = 6'h03;
    release_reset();
    cyc("badfn_fetch", 1, 0, v_fetch(1));
    cyc("badfn_decode", 1, 0, v_decode());
    cyc("badfn_trap0", 1, 1, v_trap());
    funct = 6'h20;
    cyc("badfn_trap1", 1, 0, v_trap());
    assert_reset("badfn_trap_cleared");
    release_reset();
    cyc("final_fetch", 1, 0, v_fetch(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
